// File: rtl/card_pkg.sv
// Shared constants, FSM encoding and deck-index decode for the card shoe.
package card_pkg;

   localparam int unsigned DECK_SIZE      = 52;
   localparam int unsigned RANKS_PER_SUIT = 13;
   localparam int unsigned FACE_VALUE     = 10;
   localparam int unsigned RANK_ACE       = 1;

   typedef enum logic [1:0] {
      StIdle,
      StSearch,
      StPresent
   } state_e;

   typedef struct packed {
      logic [3:0] value;
      logic [3:0] rank;
      logic [1:0] suit;
   } card_t;

   function automatic card_t card_decode(input logic [5:0] idx);
      card_t      c;
      logic [5:0] r;
      logic [5:0] rps;
      rps = 6'(RANKS_PER_SUIT);
      if (idx < rps) begin
         c.suit = 2'd0;
         r      = idx;
      end else if (idx < 6'd2 * rps) begin
         c.suit = 2'd1;
         r      = idx - rps;
      end else if (idx < 6'd3 * rps) begin
         c.suit = 2'd2;
         r      = idx - 6'd2 * rps;
      end else begin
         c.suit = 2'd3;
         r      = idx - 6'd3 * rps;
      end
      c.rank  = 4'(r + 6'(RANK_ACE));
      c.value = (c.rank > 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : c.rank;
      return c;
   endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11, reset to SEED.
module card_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: draws without repetition by probing from a start slot.
// Define CARD_SHOE_FIXED_ORDER_EN to start every probe at slot 0 (index-order dealing).
module card_shoe
   import card_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       card_req,
   input  logic       shuffle,
   output logic [3:0] card_value,
   output logic [3:0] card_rank,
   output logic [1:0] card_suit,
   output logic       card_valid,
   output logic [5:0] cards_left,
   output logic       shoe_empty,
   output logic       busy
);

   state_e      state_q, state_d;
   logic [51:0] used_q, used_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [5:0]  left_q, left_d;
   card_t       card_q, card_d;
   logic [15:0] lfsr;
   logic [5:0]  start_ptr;
   logic        lfsr_unused;

   card_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .lfsr  (lfsr)
   );

`ifdef CARD_SHOE_FIXED_ORDER_EN
   assign start_ptr   = 6'd0;
   assign lfsr_unused = ^lfsr;
`else
   // Fold 52..63 back into the deck range.
   assign start_ptr   = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE) : lfsr[5:0];
   assign lfsr_unused = ^lfsr[15:6];
`endif

   always_comb begin
      state_d = state_q;
      used_d  = used_q;
      ptr_d   = ptr_q;
      left_d  = left_q;
      card_d  = card_q;
      unique case (state_q)
         StIdle: begin
            if (shuffle) begin
               used_d = '0;
               left_d = 6'(DECK_SIZE);
            end else if (card_req && (left_q != 6'd0)) begin
               ptr_d   = start_ptr;
               state_d = StSearch;
            end
         end
         StSearch: begin
            if (!used_q[ptr_q]) begin
               used_d[ptr_q] = 1'b1;
               left_d        = left_q - 6'd1;
               card_d        = card_decode(ptr_q);
               state_d       = StPresent;
            end else begin
               ptr_d = (ptr_q == 6'(DECK_SIZE - 1)) ? 6'd0 : ptr_q + 6'd1;
            end
         end
         StPresent: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         used_q  <= '0;
         ptr_q   <= '0;
         left_q  <= 6'(DECK_SIZE);
         card_q  <= '0;
      end else begin
         state_q <= state_d;
         used_q  <= used_d;
         ptr_q   <= ptr_d;
         left_q  <= left_d;
         card_q  <= card_d;
      end
   end

   assign card_value = card_q.value;
   assign card_rank  = card_q.rank;
   assign card_suit  = card_q.suit;
   assign card_valid = (state_q == StPresent);
   assign cards_left = left_q;
   assign shoe_empty = (left_q == 6'd0);
   assign busy       = (state_q != StIdle);

endmodule
